// File: rtl/lsu_pkg.sv
// Shared types for the MEM-stage load/store unit: memory access modes,
// operation codes, exception codes and the registered request record.
package lsu_pkg;

   typedef enum logic [2:0] {
      NONE      = 3'd0,
      BYTE      = 3'd1,
      HALFWORD  = 3'd2,
      WORD      = 3'd3,
      WORDLEFT  = 3'd4,
      WORDRIGHT = 3'd5
   } mem_mode_t;

   // op[3] set means store
   typedef enum logic [3:0] {
      LB  = 4'd0,  LBU = 4'd1,  LH  = 4'd2,  LHU = 4'd3,
      LW  = 4'd4,  LWL = 4'd5,  LWR = 4'd6,
      SB  = 4'd8,  SH  = 4'd9,  SW  = 4'd10, SWL = 4'd11, SWR = 4'd12
   } lsu_op_t;

   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_DBE  = 5'd7;

   typedef struct packed {
      lsu_op_t     op;
      logic [31:0] ea;
      logic [31:0] store_data;
      logic [31:0] rt_old;
      logic [4:0]  dest;
   } lsu_req_t;

   function automatic mem_mode_t op_mode(input lsu_op_t op);
      case (op)
         LB, LBU, SB: return BYTE;
         LH, LHU, SH: return HALFWORD;
         LW, SW:      return WORD;
         LWL, SWL:    return WORDLEFT;
         LWR, SWR:    return WORDRIGHT;
         default:     return NONE;
      endcase
   endfunction

endpackage

// File: rtl/lsu_unaligned_merge.sv
// Byte-lane merge for lwl/lwr: lanes the memory did not supply keep rt_old.
module lsu_unaligned_merge
   import lsu_pkg::*;
(
   input  mem_mode_t   mode,
   input  logic [1:0]  k,
   input  logic [31:0] mem_data,
   input  logic [31:0] rt_old,
   output logic [31:0] merged
);

   // NOTE: merged gets a full default before the loop so no path leaves it unassigned (no latch).
   always_comb begin
      merged = mem_data;
      for (int lane = 0; lane < 4; lane++) begin
         // lwl fills lanes 3..3-k from memory, lwr fills lanes 0..3-k
         if ((mode == WORDLEFT && lane < 3 - int'(k)) ||
             (mode == WORDRIGHT && lane > 3 - int'(k)))
            merged[8*lane +: 8] = rt_old[8*lane +: 8];
      end
   end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store controller: one request at a time, a single-cycle memory
// access with alignment/range checks, and a held result toward writeback.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int MEM_ADDR_BITS = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_op,
   input  logic [31:0] req_base,
   input  logic [15:0] req_offset,
   input  logic [31:0] req_store_data,
   input  logic [31:0] req_rt_old,
   input  logic [4:0]  req_dest,
   output logic [31:0] mem_address,
   output logic [31:0] mem_data,
   output logic [2:0]  mem_write_mode,
   output logic [2:0]  mem_read_mode,
   output logic        mem_unsigned_load,
   output logic        mem_unaligned_left,
   output logic        mem_unaligned_right,
   input  logic [31:0] mem_read_data,
   output logic        wb_valid,
   input  logic        wb_ready,
   output logic [4:0]  wb_dest,
   output logic [31:0] wb_data,
   output logic        wb_write_en,
   output logic        exc_valid,
   output logic [4:0]  exc_code,
   output logic [31:0] exc_badvaddr
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t      state;
   lsu_req_t    req_q;
   logic [31:0] ea_next;
   mem_mode_t   mode;
   logic        store;
   logic        is_load;
   logic        exc;
   logic [4:0]  exc_cause;
   logic        access_go;
   logic [31:0] merged;

   assign ea_next = req_base + {{16{req_offset[15]}}, req_offset};
   assign mode    = op_mode(req_q.op);
   assign store   = req_q.op[3];
   assign is_load = !store && mode != NONE;

   // Alignment is checked before range; unknown ops never fault.
   always_comb begin
      exc       = 1'b0;
      exc_cause = '0;
      if ((mode == HALFWORD && req_q.ea[0]) || (mode == WORD && req_q.ea[1:0] != 2'b00)) begin
         exc       = 1'b1;
         exc_cause = store ? EXC_ADES : EXC_ADEL;
      end else if (mode != NONE && req_q.ea[31:MEM_ADDR_BITS] != '0) begin
         exc       = 1'b1;
         exc_cause = EXC_DBE;
      end
   end

   // NOTE: the memory controls decode from the registered state rather than being
   // registered themselves, so an asynchronous reset forces NONE at once and no write commits.
   assign access_go           = state == ACCESS && !exc && mode != NONE;
   assign mem_write_mode      = (access_go && store)  ? mode : NONE;
   assign mem_read_mode       = (access_go && !store) ? mode : NONE;
   assign mem_address         = access_go ? req_q.ea : '0;
   assign mem_data            = (access_go && store) ? req_q.store_data : '0;
   assign mem_unsigned_load   = access_go && !store && (req_q.op == LBU || req_q.op == LHU);
   assign mem_unaligned_left  = access_go && mode == WORDLEFT;
   assign mem_unaligned_right = access_go && mode == WORDRIGHT;

   lsu_unaligned_merge u_merge (
      .mode     (mode),
      .k        (req_q.ea[1:0]),
      .mem_data (mem_read_data),
      .rt_old   (req_q.rt_old),
      .merged   (merged)
   );

   // NOTE: all state and registered outputs use non-blocking assignments so every
   // register samples the pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         req_ready    <= 1'b1;
         req_q        <= '0;
         wb_valid     <= 1'b0;
         wb_dest      <= '0;
         wb_data      <= '0;
         wb_write_en  <= 1'b0;
         exc_valid    <= 1'b0;
         exc_code     <= '0;
         exc_badvaddr <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  req_q     <= '{op: lsu_op_t'(req_op), ea: ea_next, store_data: req_store_data,
                                 rt_old: req_rt_old, dest: req_dest};
                  req_ready <= 1'b0;
                  state     <= ACCESS;
               end
            end
            ACCESS: begin
               wb_valid     <= 1'b1;
               wb_dest      <= req_q.dest;
               wb_write_en  <= is_load && !exc;
               wb_data      <= (is_load && !exc) ? merged : '0;
               exc_valid    <= exc;
               exc_code     <= exc_cause;
               exc_badvaddr <= exc ? req_q.ea : '0;
               state        <= RESP;
            end
            RESP: begin
               if (wb_ready) begin
                  wb_valid    <= 1'b0;
                  wb_write_en <= 1'b0;
                  exc_valid   <= 1'b0;
                  req_ready   <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a byte-array memory, a transaction-level
// reference model with its own memory copy, and a per-cycle output comparator.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [3:0]  req_op = '0;
   logic [31:0] req_base = '0;
   logic [15:0] req_offset = '0;
   logic [31:0] req_store_data = '0;
   logic [31:0] req_rt_old = '0;
   logic [4:0]  req_dest = '0;
   logic [31:0] mem_address;
   logic [31:0] mem_data;
   logic [2:0]  mem_write_mode;
   logic [2:0]  mem_read_mode;
   logic        mem_unsigned_load;
   logic        mem_unaligned_left;
   logic        mem_unaligned_right;
   logic [31:0] mem_read_data = '0;
   logic        wb_valid;
   logic        wb_ready = 1'b0;
   logic [4:0]  wb_dest;
   logic [31:0] wb_data;
   logic        wb_write_en;
   logic        exc_valid;
   logic [4:0]  exc_code;
   logic [31:0] exc_badvaddr;

   always #5 clk = ~clk;

   load_store_unit #(.MEM_ADDR_BITS(16)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_base(req_base), .req_offset(req_offset), .req_store_data(req_store_data),
      .req_rt_old(req_rt_old), .req_dest(req_dest),
      .mem_address(mem_address), .mem_data(mem_data),
      .mem_write_mode(mem_write_mode), .mem_read_mode(mem_read_mode),
      .mem_unsigned_load(mem_unsigned_load), .mem_unaligned_left(mem_unaligned_left),
      .mem_unaligned_right(mem_unaligned_right), .mem_read_data(mem_read_data),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_dest(wb_dest), .wb_data(wb_data),
      .wb_write_en(wb_write_en), .exc_valid(exc_valid), .exc_code(exc_code),
      .exc_badvaddr(exc_badvaddr)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- data memory seen by the DUT (little-endian bytes) ----------------
   logic [7:0] mem [0:65535];
   logic [7:0] ref_mem [0:65535];

   function automatic logic [7:0] env_byte(input logic [31:0] a);
      return mem[a[15:0]];
   endfunction

   function automatic logic [31:0] env_read(input logic [2:0] mode, input logic [31:0] a, input logic uns);
      logic [31:0] r;
      logic [7:0]  b;
      logic [15:0] h;
      int k;
      r = '0;
      k = int'(a[1:0]);
      case (mode)
         3'd1: begin b = env_byte(a); r = uns ? {24'h0, b} : {{24{b[7]}}, b}; end
         3'd2: begin h = {env_byte(a + 32'd1), env_byte(a)}; r = uns ? {16'h0, h} : {{16{h[15]}}, h}; end
         3'd3: r = {env_byte(a + 32'd3), env_byte(a + 32'd2), env_byte(a + 32'd1), env_byte(a)};
         3'd4: for (int i = 0; i <= k; i++) r[8*(3-i) +: 8] = env_byte(a - 32'(i));
         3'd5: for (int i = 0; i <= 3 - k; i++) r[8*i +: 8] = env_byte(a + 32'(i));
         default: r = '0;
      endcase
      return r;
   endfunction

   always @(negedge clk)
      mem_read_data <= env_read(mem_read_mode, mem_address, mem_unsigned_load);

   always @(posedge clk) begin
      case (mem_write_mode)
         3'd1: mem[mem_address[15:0]] <= mem_data[7:0];
         3'd2: for (int i = 0; i < 2; i++) mem[16'(mem_address[15:0] + 16'(i))] <= mem_data[8*i +: 8];
         3'd3: for (int i = 0; i < 4; i++) mem[16'(mem_address[15:0] + 16'(i))] <= mem_data[8*i +: 8];
         3'd4: for (int i = 0; i <= int'(mem_address[1:0]); i++)
                  mem[16'(mem_address[15:0] - 16'(i))] <= mem_data[8*(3-i) +: 8];
         3'd5: for (int i = 0; i <= 3 - int'(mem_address[1:0]); i++)
                  mem[16'(mem_address[15:0] + 16'(i))] <= mem_data[8*i +: 8];
         default: ;
      endcase
   end

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [31:0] ea;
      logic        exc;
      logic [4:0]  code;
      logic        wen;
      logic [31:0] data;
      logic        store;
      logic [2:0]  mode;
      logic        uns;
      logic [31:0] sdata;
      logic [4:0]  dest;
   } exp_t;

   function automatic logic [7:0] rm(input logic [31:0] a);
      return ref_mem[a[15:0]];
   endfunction

   function automatic exp_t predict(input logic [3:0] op, input logic [31:0] base, input logic [15:0] off,
                                    input logic [31:0] sdata, input logic [31:0] rtold, input logic [4:0] dest);
      exp_t e;
      logic [7:0]  b;
      logic [15:0] h;
      int k;
      e       = '0;
      e.ea    = base + {{16{off[15]}}, off};
      e.sdata = sdata;
      e.dest  = dest;
      e.store = op[3];
      case (op)
         4'd0, 4'd8:  e.mode = 3'd1;
         4'd1:        begin e.mode = 3'd1; e.uns = 1'b1; end
         4'd2, 4'd9:  e.mode = 3'd2;
         4'd3:        begin e.mode = 3'd2; e.uns = 1'b1; end
         4'd4, 4'd10: e.mode = 3'd3;
         4'd5, 4'd11: e.mode = 3'd4;
         4'd6, 4'd12: e.mode = 3'd5;
         default:     e.mode = 3'd0;
      endcase
      k = int'(e.ea % 4);
      if ((e.mode == 3'd2 && e.ea % 2 != 0) || (e.mode == 3'd3 && k != 0)) begin
         e.exc  = 1'b1;
         e.code = e.store ? 5'd5 : 5'd4;
      end else if (e.mode != 3'd0 && e.ea >= 32'h0001_0000) begin
         e.exc  = 1'b1;
         e.code = 5'd7;
      end
      if (!e.exc && !e.store && e.mode != 3'd0) begin
         e.wen = 1'b1;
         case (e.mode)
            3'd1: begin b = rm(e.ea); e.data = e.uns ? {24'h0, b} : {{24{b[7]}}, b}; end
            3'd2: begin h = {rm(e.ea + 32'd1), rm(e.ea)}; e.data = e.uns ? {16'h0, h} : {{16{h[15]}}, h}; end
            3'd3: e.data = {rm(e.ea + 32'd3), rm(e.ea + 32'd2), rm(e.ea + 32'd1), rm(e.ea)};
            3'd4: begin
               e.data = rtold;
               for (int i = 0; i <= k; i++) e.data[8*(3-i) +: 8] = rm(e.ea - 32'(i));
            end
            default: begin
               e.data = rtold;
               for (int i = 0; i <= 3 - k; i++) e.data[8*i +: 8] = rm(e.ea + 32'(i));
            end
         endcase
      end
      return e;
   endfunction

   int   phase = 0;   // 0 idle, 1 access, 2 response
   exp_t cur   = '0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase <= 0;
      end else begin
         case (phase)
            0: if (req_valid) begin
                  cur   <= predict(req_op, req_base, req_offset, req_store_data, req_rt_old, req_dest);
                  phase <= 1;
               end
            1: begin
               if (cur.store && !cur.exc) begin
                  case (cur.mode)
                     3'd1: ref_mem[cur.ea[15:0]] <= cur.sdata[7:0];
                     3'd2: for (int i = 0; i < 2; i++) ref_mem[16'(cur.ea[15:0] + 16'(i))] <= cur.sdata[8*i +: 8];
                     3'd3: for (int i = 0; i < 4; i++) ref_mem[16'(cur.ea[15:0] + 16'(i))] <= cur.sdata[8*i +: 8];
                     3'd4: for (int i = 0; i <= int'(cur.ea[1:0]); i++)
                              ref_mem[16'(cur.ea[15:0] - 16'(i))] <= cur.sdata[8*(3-i) +: 8];
                     3'd5: for (int i = 0; i <= 3 - int'(cur.ea[1:0]); i++)
                              ref_mem[16'(cur.ea[15:0] + 16'(i))] <= cur.sdata[8*i +: 8];
                     default: ;
                  endcase
               end
               phase <= 2;
            end
            default: if (wb_ready) phase <= 0;
         endcase
      end
   end

   // ---------------- per-cycle comparator ----------------
   always @(negedge clk) begin
      if (rst) begin
         check("req_ready", {31'b0, req_ready}, {31'b0, phase == 0});
         check("wb_valid", {31'b0, wb_valid}, {31'b0, phase == 2});
         if (phase == 1 && cur.mode != 3'd0 && !cur.exc) begin
            check("mem_write_mode", {29'b0, mem_write_mode}, cur.store ? {29'b0, cur.mode} : 32'd0);
            check("mem_read_mode", {29'b0, mem_read_mode}, cur.store ? 32'd0 : {29'b0, cur.mode});
            check("mem_address", mem_address, cur.ea);
            if (cur.store) check("mem_data", mem_data, cur.sdata);
            else           check("mem_unsigned_load", {31'b0, mem_unsigned_load}, {31'b0, cur.uns});
            check("mem_unaligned_left", {31'b0, mem_unaligned_left}, {31'b0, cur.mode == 3'd4});
            check("mem_unaligned_right", {31'b0, mem_unaligned_right}, {31'b0, cur.mode == 3'd5});
         end else begin
            check("mem_write_mode_quiet", {29'b0, mem_write_mode}, 32'd0);
            check("mem_read_mode_quiet", {29'b0, mem_read_mode}, 32'd0);
         end
         if (phase == 2) begin
            check("exc_valid", {31'b0, exc_valid}, {31'b0, cur.exc});
            check("wb_write_en", {31'b0, wb_write_en}, {31'b0, cur.wen});
            check("wb_dest", {27'b0, wb_dest}, {27'b0, cur.dest});
            if (cur.exc) begin
               check("exc_code", {27'b0, exc_code}, {27'b0, cur.code});
               check("exc_badvaddr", exc_badvaddr, cur.ea);
            end
            if (cur.wen) check("wb_data", wb_data, cur.data);
         end
      end
   end

   // ---------------- directed driver ----------------
   logic [31:0] cap_data;
   logic        cap_wen;
   logic        cap_exc;
   logic [4:0]  cap_code;
   logic [31:0] cap_bad;
   int          cap_lat;

   task automatic run(input logic [3:0] op, input logic [31:0] base, input logic [15:0] off,
                      input logic [31:0] sdata, input logic [31:0] rtold, input int hold);
      @(negedge clk);
      req_op = op; req_base = base; req_offset = off; req_store_data = sdata;
      req_rt_old = rtold; req_dest = 5'(op + 4'd3); req_valid = 1'b1;
      @(posedge clk);
      cap_lat = 1;
      @(negedge clk);
      req_valid = 1'b0;
      while (!wb_valid && cap_lat < 8) begin
         @(posedge clk);
         cap_lat++;
         @(negedge clk);
      end
      if (!wb_valid) check("wb_valid_timeout", {31'b0, wb_valid}, 32'd1);
      cap_data = wb_data; cap_wen = wb_write_en; cap_exc = exc_valid;
      cap_code = exc_code; cap_bad = exc_badvaddr;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_wb_valid", {31'b0, wb_valid}, 32'd1);
         check("hold_req_ready", {31'b0, req_ready}, 32'd0);
      end
      wb_ready = 1'b1;
      @(posedge clk);
      #1 wb_ready = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 65536; i++) begin
         mem[i]     = 8'h00;
         ref_mem[i] = 8'h00;
      end
      repeat (3) @(negedge clk);
      check("rst_req_ready", {31'b0, req_ready}, 32'd1);
      check("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
      check("rst_wb_write_en", {31'b0, wb_write_en}, 32'd0);
      check("rst_exc_valid", {31'b0, exc_valid}, 32'd0);
      check("rst_wb_data", wb_data, 32'd0);
      check("rst_wb_dest", {27'b0, wb_dest}, 32'd0);
      check("rst_exc_code", {27'b0, exc_code}, 32'd0);
      check("rst_exc_badvaddr", exc_badvaddr, 32'd0);
      check("rst_mem_modes", {26'b0, mem_write_mode, mem_read_mode}, 32'd0);
      check("rst_mem_address", mem_address, 32'd0);
      check("rst_mem_data", mem_data, 32'd0);
      rst = 1'b1;

      run(4'd10, 32'h100, 16'd4, 32'hDEADBEEF, 32'h0, 0);          // SW
      check("sw_wen", {31'b0, cap_wen}, 32'd0);
      check("sw_exc", {31'b0, cap_exc}, 32'd0);
      run(4'd4, 32'h104, 16'd0, 32'h0, 32'h0, 0);                  // LW
      check("lw_data", cap_data, 32'hDEADBEEF);
      check("lw_wen", {31'b0, cap_wen}, 32'd1);
      check("lw_latency", cap_lat, 32'd2);
      run(4'd5, 32'h104, 16'd1, 32'h0, 32'h11223344, 0);           // LWL k=1
      check("lwl_data", cap_data, 32'hBEEF3344);
      run(4'd6, 32'h106, 16'd0, 32'h0, 32'h11223344, 0);           // LWR k=2
      check("lwr_data", cap_data, 32'h1122DEAD);
      run(4'd8, 32'h104, 16'd0, 32'h00000080, 32'h0, 0);           // SB
      run(4'd0, 32'h104, 16'd0, 32'h0, 32'h0, 0);                  // LB
      check("lb_data", cap_data, 32'hFFFFFF80);
      run(4'd1, 32'h104, 16'd0, 32'h0, 32'h0, 0);                  // LBU
      check("lbu_data", cap_data, 32'h00000080);
      run(4'd2, 32'h101, 16'd0, 32'h0, 32'h0, 0);                  // LH misaligned
      check("lh_exc", {31'b0, cap_exc}, 32'd1);
      check("lh_code", {27'b0, cap_code}, 32'd4);
      check("lh_badvaddr", cap_bad, 32'h101);
      check("lh_wen", {31'b0, cap_wen}, 32'd0);
      run(4'd10, 32'h102, 16'd0, 32'h55555555, 32'h0, 0);          // SW misaligned
      check("sw_code", {27'b0, cap_code}, 32'd5);
      run(4'd4, 32'h108, 16'hFFFC, 32'h0, 32'h0, 0);               // LW via negative offset
      check("lw_readback", cap_data, 32'hDEADBE80);
      run(4'd4, 32'h00010000, 16'd0, 32'h0, 32'h0, 0);             // out of range
      check("dbe_code", {27'b0, cap_code}, 32'd7);
      check("dbe_badvaddr", cap_bad, 32'h00010000);
      run(4'd9, 32'h200, 16'd2, 32'h0000CAFE, 32'h0, 0);           // SH
      run(4'd3, 32'h202, 16'd0, 32'h0, 32'h0, 0);                  // LHU
      check("lhu_data", cap_data, 32'h0000CAFE);
      run(4'd2, 32'h202, 16'd0, 32'h0, 32'h0, 0);                  // LH
      check("lh_data", cap_data, 32'hFFFFCAFE);
      run(4'd7, 32'h00020001, 16'd0, 32'h0, 32'h0, 0);             // unknown op
      check("nop_wen", {31'b0, cap_wen}, 32'd0);
      check("nop_exc", {31'b0, cap_exc}, 32'd0);
      run(4'd11, 32'h301, 16'd0, 32'hAABBCCDD, 32'h0, 0);          // SWL k=1
      run(4'd12, 32'h306, 16'd0, 32'h11223344, 32'h0, 0);          // SWR k=2
      run(4'd4, 32'h300, 16'd0, 32'h0, 32'h0, 0);
      check("swl_readback", cap_data, 32'h0000AABB);
      run(4'd4, 32'h304, 16'd0, 32'h0, 32'h0, 0);
      check("swr_readback", cap_data, 32'h33440000);
      run(4'd4, 32'h104, 16'd0, 32'h0, 32'h0, 5);                  // held response
      check("hold_data", cap_data, 32'hDEADBE80);

      // reset in the middle of a store access
      @(negedge clk);
      req_op = 4'd10; req_base = 32'h400; req_offset = 16'd0;
      req_store_data = 32'h12345678; req_valid = 1'b1;
      @(posedge clk);
      #1 check("abort_pre_mode", {29'b0, mem_write_mode}, 32'd3);
      #1 rst = 1'b0;
      #1;
      check("abort_wmode", {29'b0, mem_write_mode}, 32'd0);
      check("abort_rmode", {29'b0, mem_read_mode}, 32'd0);
      check("abort_req_ready", {31'b0, req_ready}, 32'd1);
      check("abort_wb_valid", {31'b0, wb_valid}, 32'd0);
      check("abort_wb_data", wb_data, 32'd0);
      check("abort_mem_data", mem_data, 32'd0);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      run(4'd4, 32'h400, 16'd0, 32'h0, 32'h0, 0);
      check("abort_no_write", cap_data, 32'h00000000);

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- MEM-stage controller sitting directly upstream of the byte-addressed data memory.
- Accepts one load/store request at a time from execute via valid/ready.
- Computes the effective address and checks alignment and range.
- Drives the memory's mode/address/data inputs for exactly one cycle, merges lwl/lwr partial words with the old rt value, and hands the result to writeback via valid/ready.

Parameters:
- MEM_ADDR_BITS, 16, implemented memory address width; any set bit in ea[31:MEM_ADDR_BITS] is a bus error.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- req_valid  in  1  request offered by execute
- req_ready  out  1  unit can accept a request
- req_op  in  4  lsu_op_t operation code
- req_base  in  32  rs value
- req_offset  in  16  signed immediate
- req_store_data  in  32  rt value for stores
- req_rt_old  in  32  current rt value, used for lwl/lwr merge
- req_dest  in  5  destination register index
- mem_address  out  32  to memory address
- mem_data  out  32  to memory write data
- mem_write_mode  out  3  mem_mode_t
- mem_read_mode  out  3  mem_mode_t
- mem_unsigned_load  out  1  zero-extend byte/halfword loads
- mem_unaligned_left  out  1  lwl/swl access
- mem_unaligned_right  out  1  lwr/swr access
- mem_read_data  in  32  combinational read data from memory
- wb_valid  out  1  result or exception available
- wb_ready  in  1  writeback consumes the result
- wb_dest  out  5  destination register
- wb_data  out  32  load result
- wb_write_en  out  1  register write required (loads, no exception)
- exc_valid  out  1  exception reported with wb_valid
- exc_code  out  5  4 = AdEL, 5 = AdES, 7 = DBE
- exc_badvaddr  out  32  faulting effective address

Behaviour:
- Reset (rst low, async):
  - State IDLE; req_ready=1.
  - wb_valid, exc_valid and wb_write_en are 0; wb_data, wb_dest, exc_code and exc_badvaddr are 0.
  - Both mem modes are NONE; all other mem outputs are 0.
- States: IDLE, ACCESS, RESP. req_ready is 1 only in IDLE.
- IDLE:
  - On req_valid, register the op fields and ea = req_base + sign-extended req_offset (32-bit wrap, no overflow trap), then go to ACCESS.
  - An unknown op is accepted and treated as a NOP: ACCESS drives NONE, RESP gives wb_write_en=0.
- Checks, done in ACCESS on the registered ea; the first match wins:
  - lh/lhu/sh with ea[0]=1 gives AdEL (load) or AdES (store).
  - lw/sw with ea[1:0]!=0 gives AdEL/AdES.
  - lwl/lwr/swl/swr never raise an alignment fault.
  - Out of range (ea[31:MEM_ADDR_BITS] nonzero) gives DBE.
- ACCESS, exactly 1 cycle:
  - With no exception, drive mem_address=ea and the mode from the op (lb/lbu/sb BYTE, lh/lhu/sh HALFWORD, lw/sw WORD, lwl/swl WORDLEFT, lwr/swr WORDRIGHT).
  - The store mode appears on mem_write_mode only, with mem_data=store data.
  - The load mode appears on mem_read_mode only; sample mem_read_data into wb_data at the cycle end.
  - On exception, both modes are NONE; no write occurs.
  - The store commits at the clk edge that ends ACCESS. Go to RESP.
- lwl merge, k=ea[1:0]: memory returns k+1 valid bytes in the upper bytes, zero below. wb_data = upper k+1 bytes from memory, remaining bytes from rt_old.
- lwr merge, k=ea[1:0]: memory returns 4-k valid bytes in the lower bytes. wb_data = lower 4-k bytes from memory, remaining bytes from rt_old.
- RESP:
  - wb_valid=1; wb_write_en=1 for loads without exception.
  - All wb_*/exc_* outputs are held stable until wb_ready.
  - When wb_ready is sampled, go to IDLE. Next request accepted no earlier than the following cycle; throughput is 1 request per 3 cycles minimum.
- All mem modes are NONE in every state except ACCESS, so no stray writes occur.
- Reset asserted mid-ACCESS aborts the access; the memory sees NONE immediately and no write commits.
- Latency: accept edge to wb_valid = 2 cycles.

Decomposition:
- Package lsu_pkg holds:
  - mem_mode_t: NONE=0, BYTE=1, HALFWORD=2, WORD=3, WORDLEFT=4, WORDRIGHT=5.
  - lsu_op_t: LB=0, LBU=1, LH=2, LHU=3, LW=4, LWL=5, LWR=6, SB=8, SH=9, SW=10, SWL=11, SWR=12; op[3] means store.
  - exc_code constants EXC_ADEL=4, EXC_ADES=5, EXC_DBE=7.
- Sub-module lsu_unaligned_merge: combinational lwl/lwr byte-lane merge, inputs mode, k, mem data, rt_old.

Test Plan:
- SW base=0x100 off=4 data=0xDEADBEEF, then LW base=0x104 off=0 -> wb_data=0xDEADBEEF, wb_write_en=1, wb_valid 2 cycles after accept.
- LB at 0x104 (byte 0x80 stored) -> wb_data=0xFFFFFF80; LBU -> 0x00000080.
- LH base=0x101 -> exc_valid=1, exc_code=4, exc_badvaddr=0x101, wb_write_en=0; SW at 0x102 -> code 5 and memory unchanged on read-back.
- LWL ea=0x105 (k=1), memory returns 0xBEEF0000, rt_old=0x11223344 -> wb_data=0xBEEF3344. LWR ea=0x106 (k=2), memory returns 0x0000DEAD -> wb_data=0x1122DEAD.
- base=0x00010000 LW -> exc_code=7, mem modes remain NONE throughout.
- Hold wb_ready=0 for 5 cycles in RESP -> outputs stable, req_ready=0; assert rst mid-ACCESS of SW -> no memory write, outputs at reset values.
